// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage: valid/ready with 2-entry skid (MODE=0) or legacy STALL (MODE=1).
// Optional perf counters enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_elastic #(
    parameter int                DATA_W    = 128,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                MODE      = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic [1:0]        STALL,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [31:0]       PERF_BUBBLE_CNT,
    output logic [31:0]       PERF_BACKP_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nx;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] m_nx;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] s_nx;
    logic              v_q;
    logic              v_nx;
    logic              rdy_q;
    logic              accept;
    logic              deliver;

    assign accept  = IN_VALID & rdy_q;
    assign deliver = v_q & OUT_READY;

    always_comb begin
        state_nx = state_q;
        m_nx     = m_q;
        s_nx     = s_q;
        v_nx     = v_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_nx = ONE;
                    m_nx     = IN_DATA;
                    v_nx     = 1'b1;
                end
            end
            ONE: begin
                if (deliver && accept) begin
                    m_nx = IN_DATA;
                end else if (deliver) begin
                    state_nx = EMPTY;
                    m_nx     = NOP_VALUE;
                    v_nx     = 1'b0;
                end else if (accept) begin
                    state_nx = TWO;
                    s_nx     = IN_DATA;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_nx = ONE;
                    m_nx     = s_q;
                end
            end
            default: begin
                state_nx = EMPTY;
                m_nx     = NOP_VALUE;
                v_nx     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= EMPTY;
            m_q     <= NOP_VALUE;
            s_q     <= '0;
            v_q     <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (FLUSH) begin
            state_q <= EMPTY;
            m_q     <= NOP_VALUE;
            s_q     <= '0;
            v_q     <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (MODE == 1) begin
            // Legacy stall vector; skid register and FSM stay idle
            rdy_q <= 1'b1;
            if (STALL == 2'b01) begin
                v_q <= 1'b0;
                m_q <= NOP_VALUE;
            end else if (!STALL[0]) begin
                v_q <= 1'b1;
                m_q <= IN_DATA;
            end
        end else begin
            state_q <= state_nx;
            m_q     <= m_nx;
            s_q     <= s_nx;
            v_q     <= v_nx;
            rdy_q   <= (state_nx != TWO);
        end
    end

    assign IN_READY  = (MODE == 1) ? 1'b1 : rdy_q;
    assign OUT_VALID = v_q;
    assign OUT_DATA  = m_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] bub_cnt_q;
    logic [31:0] bp_cnt_q;
    logic        bp_cond;

    assign bp_cond = (MODE == 1) ? (v_q & STALL[1]) : (v_q & ~OUT_READY);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bub_cnt_q <= '0;
            bp_cnt_q  <= '0;
        end else begin
            if (!v_q && bub_cnt_q != 32'hFFFF_FFFF)
                bub_cnt_q <= bub_cnt_q + 32'd1;
            if (bp_cond && bp_cnt_q != 32'hFFFF_FFFF)
                bp_cnt_q <= bp_cnt_q + 32'd1;
        end
    end

    assign PERF_BUBBLE_CNT = bub_cnt_q;
    assign PERF_BACKP_CNT  = bp_cnt_q;
`else
    assign PERF_BUBBLE_CNT = 32'h0;
    assign PERF_BACKP_CNT  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: handshake instance plus legacy instance.
// Counter checks follow PIPE_STAGE_PERF_CNT_EN.
module tb_pipe_stage_elastic;

    localparam int          W   = 16;
    localparam logic [15:0] NOP = 16'hDEAD;

    logic          CLK;
    logic          RST;
    logic          FLUSH;
    logic          iv0;
    logic          ir0;
    logic [W-1:0]  id0;
    logic          ov0;
    logic          or0;
    logic [W-1:0]  od0;
    logic [31:0]   bub0;
    logic [31:0]   bp0;
    logic [1:0]    stall1;
    logic          ir1;
    logic [W-1:0]  id1;
    logic          ov1;
    logic [W-1:0]  od1;
    logic [31:0]   bub1;
    logic [31:0]   bp1;

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    pipe_stage_elastic #(.DATA_W(W), .NOP_VALUE(NOP), .MODE(0)) dut0 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(2'b00),
        .IN_VALID(iv0), .IN_READY(ir0), .IN_DATA(id0),
        .OUT_VALID(ov0), .OUT_READY(or0), .OUT_DATA(od0),
        .PERF_BUBBLE_CNT(bub0), .PERF_BACKP_CNT(bp0)
    );

    pipe_stage_elastic #(.DATA_W(W), .NOP_VALUE(NOP), .MODE(1)) dut1 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(stall1),
        .IN_VALID(1'b0), .IN_READY(ir1), .IN_DATA(id1),
        .OUT_VALID(ov1), .OUT_READY(1'b0), .OUT_DATA(od1),
        .PERF_BUBBLE_CNT(bub1), .PERF_BACKP_CNT(bp1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        iv0 = 1'b1;
        id0 = d;
        exp_q.push_back(d);
        step();
    endtask

    // Monitor: every delivered beat must match the oldest expected one
    always @(negedge CLK) begin
        if (RST && ov0 && or0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL deliver_unexpected: got %0h expected none", od0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (od0 !== e) begin
                    failures++;
                    $display("FAIL deliver_order: got %0h expected %0h", od0, e);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b0;
        FLUSH    = 1'b0;
        iv0      = 1'b1;
        id0      = 16'h00A5;
        or0      = 1'b1;
        stall1   = 2'b11;
        id1      = 16'h00A5;

        // Reset held 3 cycles with a beat offered
        repeat (3) step();
        chk("rst_out_valid", {31'b0, ov0}, 32'd0);
        chk("rst_out_data", {16'b0, od0}, {16'b0, NOP});
        chk("rst_in_ready", {31'b0, ir0}, 32'd0);
        chk("rst_l_out_data", {16'b0, od1}, {16'b0, NOP});
        RST = 1'b1;
        iv0 = 1'b0;
        step();
        chk("rel_in_ready", {31'b0, ir0}, 32'd1);
        chk("rel_out_valid", {31'b0, ov0}, 32'd0);

        // Streaming, 1-cycle latency
        or0 = 1'b1;
        send(16'd1);
        chk("stream_d1", {16'b0, od0}, 32'd1);
        send(16'd2);
        chk("stream_d2", {16'b0, od0}, 32'd2);
        chk("stream_rdy", {31'b0, ir0}, 32'd1);
        send(16'd3);
        chk("stream_d3", {16'b0, od0}, 32'd3);
        iv0 = 1'b0;
        id0 = 'x;
        step();
        chk("stream_empty_v", {31'b0, ov0}, 32'd0);
        chk("stream_empty_d", {16'b0, od0}, {16'b0, NOP});
        step();
        chk("x_no_prop", {16'b0, od0}, {16'b0, NOP});

        // Skid: fill both entries, then drain
        or0 = 1'b0;
        send(16'd7);
        chk("skid_rdy1", {31'b0, ir0}, 32'd1);
        send(16'd8);
        chk("skid_rdy0", {31'b0, ir0}, 32'd0);
        iv0 = 1'b0;
        step();
        chk("skid_hold_d", {16'b0, od0}, 32'd7);
        chk("skid_hold_v", {31'b0, ov0}, 32'd1);
        or0 = 1'b1;
        step();
        chk("skid_d8", {16'b0, od0}, 32'd8);
        chk("skid_rdy_back", {31'b0, ir0}, 32'd1);
        step();
        chk("skid_drained", {31'b0, ov0}, 32'd0);

        // Flush while TWO with a beat offered
        or0 = 1'b0;
        send(16'd7);
        send(16'd8);
        exp_q.delete();
        FLUSH = 1'b1;
        iv0   = 1'b1;
        id0   = 16'd9;
        step();
        FLUSH = 1'b0;
        iv0   = 1'b0;
        chk("flush_v", {31'b0, ov0}, 32'd0);
        chk("flush_d", {16'b0, od0}, {16'b0, NOP});
        chk("flush_rdy", {31'b0, ir0}, 32'd1);
        or0 = 1'b1;
        repeat (3) step();
        chk("flush_no9", {31'b0, ov0}, 32'd0);

        // Legacy stall vector
        id1    = 16'h0011;
        stall1 = 2'b00;
        step();
        chk("leg_load_v", {31'b0, ov1}, 32'd1);
        chk("leg_load_d", {16'b0, od1}, 32'h11);
        chk("leg_rdy", {31'b0, ir1}, 32'd1);
        id1    = 16'h0022;
        stall1 = 2'b11;
        step();
        chk("leg_hold", {16'b0, od1}, 32'h11);
        stall1 = 2'b01;
        step();
        chk("leg_bub_v", {31'b0, ov1}, 32'd0);
        chk("leg_bub_d", {16'b0, od1}, {16'b0, NOP});
        id1    = 16'h0033;
        stall1 = 2'b10;
        step();
        chk("leg_s10_d", {16'b0, od1}, 32'h33);
        FLUSH  = 1'b1;
        id1    = 16'h0044;
        stall1 = 2'b00;
        step();
        FLUSH  = 1'b0;
        stall1 = 2'b11;
        chk("leg_flush_v", {31'b0, ov1}, 32'd0);
        chk("leg_flush_d", {16'b0, od1}, {16'b0, NOP});

        // Counters: fresh reset, 5 bubble cycles then 2 back-pressure cycles
        RST = 1'b0;
        step();
        RST = 1'b1;
        or0 = 1'b0;
        repeat (4) step();
        iv0 = 1'b1;
        id0 = 16'h0055;
        exp_q.push_back(16'h0055);
        step();
        iv0 = 1'b0;
        repeat (2) step();
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("cnt_bubble", bub0, 32'd5);
        chk("cnt_backp", bp0, 32'd2);
        or0 = 1'b1;
        step();
        force dut0.bub_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut0.bub_cnt_q;
        step();
        step();
        chk("cnt_saturate", bub0, 32'hFFFF_FFFF);
`else
        chk("cnt_off_bubble", bub0, 32'd0);
        chk("cnt_off_backp", bp0, 32'd0);
        or0 = 1'b1;
        step();
        step();
`endif
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
